// File: rtl/sid_filter_output_path.sv
// SID analogue back end: state-variable filter, post-filter mixer with DC offset,
// saturating clipper and 15 kHz one-pole output smoother.
module sid_filter_output_path #(
  parameter int MIXER_DC = -3746,
  parameter int OUT_K    = 6177
) (
  input  logic               clk,
  input  logic               iRst,
  input  logic               clkEn,
  input  logic               iWE,
  input  logic [4:0]         iAddr,
  input  logic [7:0]         iData,
  input  logic               i6581,
  input  logic signed [15:0] iIn,
  input  logic signed [15:0] iBypass,
  output logic signed [15:0] oLP,
  output logic signed [15:0] oBP,
  output logic signed [15:0] oHP,
  output logic signed [15:0] oOut
);

  localparam int unsigned FC_W  = 11;
  localparam int unsigned RES_W = 4;
  localparam int unsigned MOD_W = 3;
  // One guard bit beyond the 18-bit mixer sum so four full-scale terms plus DC never wrap
  localparam int unsigned MIX_W = 19;

  localparam logic [4:0] ADDR_FC_LO = 5'h15;
  localparam logic [4:0] ADDR_FC_HI = 5'h16;
  localparam logic [4:0] ADDR_RES   = 5'h17;
  localparam logic [4:0] ADDR_MODE  = 5'h18;

  localparam logic [15:0] F_MAX = 16'd5130;

  function automatic logic signed [15:0] sat16(input logic signed [31:0] x);
    if (x > 32'sd32767)       sat16 = 16'sh7fff;
    else if (x < -32'sd32768) sat16 = 16'sh8000;
    else                      sat16 = 16'(x);
  endfunction

  logic [FC_W-1:0]    fc_q,   fc_d;
  logic [RES_W-1:0]   res_q,  res_d;
  logic [MOD_W-1:0]   mode_q, mode_d;
  logic signed [15:0] lp_q, lp_d, bp_q, bp_d, hp_q, hp_d;
  logic signed [15:0] mix_q, mix_d;
  logic signed [15:0] y_q, y_d;

  logic [15:0]        cutoff_c, f8580_c, f6581_c;
  logic [15:0]        damp_c;
  logic signed [31:0] bp_damp_c, hp_sum_c, bp_sum_c, lp_sum_c;
  logic signed [MIX_W-1:0] mix_sum_c;
  logic signed [16:0] out_diff_c;
  logic signed [31:0] out_prod_c, y_sum_c;

  // Register bank decode; writes are not gated by the sample enable
  always_comb begin
    fc_d   = fc_q;
    res_d  = res_q;
    mode_d = mode_q;
    if (iWE) begin
      case (iAddr)
        ADDR_FC_LO: fc_d[2:0]  = iData[2:0];
        ADDR_FC_HI: fc_d[10:3] = iData;
        ADDR_RES:   res_d      = iData[7:4];
        ADDR_MODE:  mode_d     = iData[6:4];
        default: ;
      endcase
    end
  end

  // Cutoff curve (Q0.16) and damping (Q1.12)
  always_comb begin
    f8580_c  = {4'b0, fc_q, 1'b0} + {6'b0, fc_q[10:1]} + 16'd13;
    f6581_c  = {5'b0, fc_q} + {6'b0, fc_q[10:1]} + 16'd1300;
    cutoff_c = i6581 ? ((f6581_c > F_MAX) ? F_MAX : f6581_c) : f8580_c;
    damp_c   = 16'd5792 - {4'b0, res_q, 8'b0};
  end

  // State-variable filter step; lp integrates the freshly updated bp
  always_comb begin
    bp_damp_c = 32'(bp_q) * $signed({16'd0, damp_c});
    hp_sum_c  = 32'(iIn) - 32'(lp_q) - (bp_damp_c >>> 12);
    hp_d      = sat16(hp_sum_c);
    bp_sum_c  = 32'(bp_q) + ((32'(hp_d) * $signed({16'd0, cutoff_c})) >>> 16);
    bp_d      = sat16(bp_sum_c);
    lp_sum_c  = 32'(lp_q) + ((32'(bp_d) * $signed({16'd0, cutoff_c})) >>> 16);
    lp_d      = sat16(lp_sum_c);
  end

  // Post-filter mixer and clipper
  always_comb begin
    mix_sum_c = MIX_W'(iBypass) + MIX_W'(MIXER_DC)
              + (mode_q[0] ? MIX_W'(lp_q) : '0)
              + (mode_q[1] ? MIX_W'(bp_q) : '0)
              + (mode_q[2] ? MIX_W'(hp_q) : '0);
    mix_d     = sat16(32'(mix_sum_c));
  end

  // 15 kHz one-pole smoother on the clipped mix
  always_comb begin
    out_diff_c = 17'(mix_q) - 17'(y_q);
    out_prod_c = 32'(out_diff_c) * OUT_K;
    y_sum_c    = 32'(y_q) + (out_prod_c >>> 16);
    y_d        = sat16(y_sum_c);
  end

  always_ff @(posedge clk or negedge iRst) begin
    if (!iRst) begin
      fc_q   <= '0;
      res_q  <= '0;
      mode_q <= '0;
      lp_q   <= '0;
      bp_q   <= '0;
      hp_q   <= '0;
      mix_q  <= '0;
      y_q    <= '0;
    end else begin
      fc_q   <= fc_d;
      res_q  <= res_d;
      mode_q <= mode_d;
      mix_q  <= mix_d;
      if (clkEn) begin
        lp_q <= lp_d;
        bp_q <= bp_d;
        hp_q <= hp_d;
        y_q  <= y_d;
      end
    end
  end

  assign oLP  = lp_q;
  assign oBP  = bp_q;
  assign oHP  = hp_q;
  assign oOut = y_q;

endmodule

// File: tb/tb_sid_filter_output_path.sv
// Directed bench for sid_filter_output_path: reset, enable gating, register decode,
// LP settling, clipper limits, mode timing and asynchronous reset.
module tb_sid_filter_output_path;

  logic               clk = 1'b0;
  logic               iRst, clkEn, iWE, i6581;
  logic [4:0]         iAddr;
  logic [7:0]         iData;
  logic signed [15:0] iIn, iBypass;
  logic signed [15:0] oLP, oBP, oHP, oOut;

  int n_tests = 0;
  int n_fail  = 0;

  sid_filter_output_path dut (
    .clk     (clk),
    .iRst    (iRst),
    .clkEn   (clkEn),
    .iWE     (iWE),
    .iAddr   (iAddr),
    .iData   (iData),
    .i6581   (i6581),
    .iIn     (iIn),
    .iBypass (iBypass),
    .oLP     (oLP),
    .oBP     (oBP),
    .oHP     (oHP),
    .oOut    (oOut)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic wr(input logic [4:0] a, input logic [7:0] d);
    iWE = 1'b1; iAddr = a; iData = d;
    tick();
    iWE = 1'b0; iAddr = 5'h00; iData = 8'h00;
  endtask

  task automatic check(input string tag, input int obs, input int exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_rng(input string tag, input int obs, input int lo, input int hi);
    n_tests++;
    assert (obs >= lo && obs <= hi)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d..%0d", tag, obs, lo, hi);
    end
  endtask

  initial begin
    iRst = 1'b0; clkEn = 1'b0; iWE = 1'b0; i6581 = 1'b0;
    iAddr = 5'h00; iData = 8'h00; iIn = 16'sd0; iBypass = 16'sd0;

    // Reset held
    run(3);
    check("rst_lp",  oLP,  0);
    check("rst_bp",  oBP,  0);
    check("rst_hp",  oHP,  0);
    check("rst_out", oOut, 0);
    check("rst_mix", dut.mix_q, 0);

    // Release: mixer picks up the DC offset one clk later
    iRst = 1'b1;
    tick();
    check("mix_dc", dut.mix_q, -3746);

    // Enable low freezes the filter while iIn steps
    iIn = 16'sd10000;
    run(50);
    check("gate_lp",  oLP,  0);
    check("gate_bp",  oBP,  0);
    check("gate_hp",  oHP,  0);
    check("gate_out", oOut, 0);
    check("gate_mix", dut.mix_q, -3746);

    // Single sample, f=13, damp=5792
    clkEn = 1'b1;
    tick();
    clkEn = 1'b0;
    check("step_hp",  oHP,  10000);
    check("step_bp",  oBP,  1);
    check("step_lp",  oLP,  0);
    check("step_out", oOut, -354);

    // Output pole settles on the DC offset
    iIn = 16'sd0;
    clkEn = 1'b1;
    run(200);
    clkEn = 1'b0;
    check_rng("dc_settle", oOut, -3748, -3744);

    // Register decode
    wr(5'h15, 8'h00);
    wr(5'h16, 8'h00);
    check("f8580_fc0", dut.cutoff_c, 13);
    i6581 = 1'b1;
    #1;
    check("f6581_fc0", dut.cutoff_c, 1300);
    i6581 = 1'b0;
    iAddr = 5'h16; iData = 8'hFF;
    tick();
    iAddr = 5'h00; iData = 8'h00;
    check("we_low_fc", dut.fc_q, 0);
    wr(5'h14, 8'hFF);
    check("addr14_fc",   dut.fc_q,   0);
    check("addr14_res",  dut.res_q,  0);
    check("addr14_mode", dut.mode_q, 0);
    wr(5'h17, 8'hF0);
    check("res15",  dut.res_q,  15);
    check("damp15", dut.damp_c, 1952);

    // LP configuration: fc=2047, res 0, LP only
    wr(5'h15, 8'h07);
    wr(5'h16, 8'hFF);
    wr(5'h17, 8'h00);
    wr(5'h18, 8'h10);
    check("fc_max",  dut.fc_q,    2047);
    check("damp0",   dut.damp_c,  5792);
    check("f8580_max", dut.cutoff_c, 5130);
    i6581 = 1'b1;
    #1;
    check("f6581_max", dut.cutoff_c, 4370);
    i6581 = 1'b0;
    iIn = 16'sd8000;
    iBypass = 16'sd3746;
    clkEn = 1'b1;
    run(2000);
    clkEn = 1'b0;
    // Rest point needs hp and bp inside the floor-shift dead band [0,12]
    check_rng("lp_settle",  oLP,  7972, 8000);
    check_rng("bp_settle",  oBP,  0, 12);
    check_rng("hp_settle",  oHP,  0, 12);
    check_rng("out_settle", oOut, 7962, 8000);

    // Clip high with LP engaged
    iBypass = 16'sh7fff;
    tick();
    check("clip_hi", dut.mix_q, 32767);

    // Mode write reaches the mixer one clk after the write edge
    wr(5'h18, 8'h00);
    check("mode_off_old", dut.mix_q, 32767);
    tick();
    check("mode_off_new", dut.mix_q, 29021);
    wr(5'h18, 8'h10);
    check("mode_lp_old", dut.mix_q, 29021);
    tick();
    check("mode_lp_new", dut.mix_q, 32767);

    // Clip low with mode 0
    wr(5'h18, 8'h00);
    iBypass = 16'sh8000;
    tick();
    check("clip_lo", dut.mix_q, -32768);

    // Asynchronous reset between clock edges
    wr(5'h18, 8'h70);
    iIn = 16'sd5000;
    iBypass = 16'sd1000;
    clkEn = 1'b1;
    run(20);
    #2;
    iRst = 1'b0;
    #1;
    check("arst_lp",  oLP,  0);
    check("arst_bp",  oBP,  0);
    check("arst_hp",  oHP,  0);
    check("arst_out", oOut, 0);
    check("arst_mix", dut.mix_q, 0);
    check("arst_mode", dut.mode_q, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
